// File: rtl/controller_pkg.sv
// Shared constants and state encoding for the BLAKE2 controller block assembler.
package controller_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_FILL = 3'd1;
    localparam logic [2:0] ST_CAPT = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_SEND = 3'd4;

    typedef logic [2:0] state_t;

    localparam int DEF_DBITS    = 2;
    localparam int DEF_RD_PKT   = 4;
    localparam int DEF_BLK_PKTS = 16;
    localparam int DEF_PKT_W    = DEF_DBITS * DEF_RD_PKT;
    localparam int DEF_BLK_W    = DEF_PKT_W * DEF_BLK_PKTS;
    localparam int DEF_IDX_W    = $clog2(DEF_BLK_PKTS);

    // A block of a single packet still needs a one-bit slot index.
    function automatic int idx_width(input int blk_pkts);
        return (blk_pkts > 1) ? $clog2(blk_pkts) : 1;
    endfunction

endpackage

// File: rtl/controller_blk_buffer.sv
// Slot register holding one message block; packet slot 0 sits in the LSBs of data.
module controller_blk_buffer #(
    parameter int PKT_W    = 8,
    parameter int BLK_PKTS = 16,
    parameter int IDX_W    = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clr,
    input  logic                      we,
    input  logic [IDX_W-1:0]          widx,
    input  logic [PKT_W-1:0]          wdata,
    output logic [PKT_W*BLK_PKTS-1:0] data
);

    logic [PKT_W-1:0] slot [BLK_PKTS];

    // Clear wins over write so a new message never inherits a stale slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BLK_PKTS; i++) slot[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < BLK_PKTS; i++) slot[i] <= '0;
        end else if (we) begin
            slot[widx] <= wdata;
        end
    end

    always_comb begin
        data = '0;
        for (int i = 0; i < BLK_PKTS; i++) data[i*PKT_W +: PKT_W] = slot[i];
    end

endmodule

// File: rtl/controller_block_assembler.sv
// Pops FIFO packets, packs BLK_PKTS of them into a block and offers it to the compression core.
module controller_block_assembler
    import controller_pkg::*;
#(
    parameter int dbits    = 2,
    parameter int rd_pkt   = 4,
    parameter int BLK_PKTS = 16,
    parameter int tbits    = 16,
    localparam int PKT_W   = dbits * rd_pkt,
    localparam int BLK_W   = PKT_W * BLK_PKTS,
    localparam int IDX_W   = idx_width(BLK_PKTS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             msg_end,
    input  logic             fifo_empty,
    input  logic [PKT_W-1:0] fifo_dout,
    output logic             fifo_rd,
    output logic [BLK_W-1:0] blk_data,
    output logic [tbits-1:0] blk_t,
    output logic             blk_last,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic             busy
);

    // Handshake: a block transfers on a cycle where blk_valid && blk_ready; while blk_valid
    // is high and blk_ready low, blk_data/blk_t/blk_last are held unchanged.

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [tbits-1:0] t;
    logic             last_q;
    logic             blk_full;
    logic             buf_clr;
    logic             buf_we;

    assign blk_full  = (idx == IDX_W'(BLK_PKTS - 1));
    assign fifo_rd   = (state == ST_FILL) && !fifo_empty;
    assign blk_valid = (state == ST_SEND);
    assign busy      = (state != ST_IDLE);
    assign blk_t     = t;
    assign blk_last  = last_q;
    assign buf_we    = (state == ST_CAPT);
    assign buf_clr   = ((state == ST_IDLE) && start) || ((state == ST_SEND) && blk_ready);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_FILL;
            ST_FILL: begin
                if (!fifo_empty)  state_nxt = ST_CAPT;
                else if (msg_end) state_nxt = ST_SEND;
            end
            ST_CAPT: state_nxt = blk_full ? ST_HOLD : ST_FILL;
            ST_HOLD: if (!fifo_empty || msg_end) state_nxt = ST_SEND;
            ST_SEND: if (blk_ready) state_nxt = last_q ? ST_IDLE : ST_FILL;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            t      <= '0;
            last_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (start) begin
                    idx    <= '0;
                    t      <= '0;
                    last_q <= 1'b0;
                end
                ST_FILL: if (fifo_empty && msg_end) last_q <= 1'b1;
                ST_CAPT: begin
                    idx <= blk_full ? '0 : idx + IDX_W'(1);
                    t   <= t + tbits'(1);
                end
                // Pending data means more blocks follow, so last stays clear.
                ST_HOLD: if (fifo_empty && msg_end) last_q <= 1'b1;
                ST_SEND: if (blk_ready) begin
                    idx    <= '0;
                    last_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    controller_blk_buffer #(
        .PKT_W    (PKT_W),
        .BLK_PKTS (BLK_PKTS),
        .IDX_W    (IDX_W)
    ) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (buf_clr),
        .we      (buf_we),
        .widx    (idx),
        .wdata   (fifo_dout),
        .data    (blk_data)
    );

endmodule

// File: tb/tb_controller_block_assembler.sv
// Scoreboard bench for controller_block_assembler with a small FIFO model and a block-level reference.
module tb_controller_block_assembler;

    localparam int DBITS = 2;
    localparam int RDPKT = 4;
    localparam int NPK   = 4;
    localparam int TB    = 8;
    localparam int PW    = DBITS * RDPKT;
    localparam int BW    = PW * NPK;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          msg_end;
    logic          fifo_empty;
    logic [PW-1:0] fifo_dout;
    logic          fifo_rd;
    logic [BW-1:0] blk_data;
    logic [TB-1:0] blk_t;
    logic          blk_last;
    logic          blk_valid;
    logic          blk_ready;
    logic          busy;

    typedef struct packed {
        logic [BW-1:0] data;
        logic [TB-1:0] t;
        logic          last;
    } blk_s;

    blk_s          exp_q[$];
    logic [PW-1:0] fifo_q[$];
    logic [PW-1:0] msg_pkts[$];

    int checks   = 0;
    int failures = 0;

    controller_block_assembler #(
        .dbits    (DBITS),
        .rd_pkt   (RDPKT),
        .BLK_PKTS (NPK),
        .tbits    (TB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .msg_end    (msg_end),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .blk_data   (blk_data),
        .blk_t      (blk_t),
        .blk_last   (blk_last),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .busy       (busy)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: read data appears the cycle after the pop strobe; flag follows one edge after a push.
    initial begin
        fifo_empty = 1'b1;
        fifo_dout  = '0;
    end
    always @(posedge clk) begin
        if (fifo_rd && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: packets grouped into blocks of NPK, slot 0 in LSBs, t counts real packets only,
    // an empty message yields a single all-zero final block.
    task automatic expect_msg();
        int   n;
        int   nblk;
        blk_s b;
        n    = msg_pkts.size();
        nblk = (n == 0) ? 1 : (n + NPK - 1) / NPK;
        for (int bi = 0; bi < nblk; bi++) begin
            b.data = '0;
            for (int s = 0; s < NPK; s++) begin
                if (bi * NPK + s < n) b.data = b.data | (BW'(msg_pkts[bi * NPK + s]) << (PW * s));
            end
            b.t    = TB'((n < (bi + 1) * NPK) ? n : (bi + 1) * NPK);
            b.last = (bi == nblk - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd_rdy);
        int c;
        c = 0;
        while (c < budget && (busy || exp_q.size() != 0)) begin
            if (rnd_rdy) blk_ready = 1'($urandom_range(0, 1));
            tick(1);
            c++;
        end
        check("done_in_budget", 64'(c < budget), 64'd1);
        check("idle_after_msg", 64'(busy), 64'd0);
        blk_ready = 1'b1;
        msg_end   = 1'b0;
    endtask

    // Whole message queued up front, msg_end high from the start.
    task automatic run_preloaded(input bit rnd_rdy);
        expect_msg();
        foreach (msg_pkts[i]) fifo_q.push_back(msg_pkts[i]);
        msg_end = 1'b1;
        tick(1);
        pulse_start();
        wait_done(600, rnd_rdy);
    endtask

    // Packets trickle in; msg_end rises only once the flag has had time to reflect the last push.
    task automatic run_gradual();
        expect_msg();
        msg_end = 1'b0;
        pulse_start();
        foreach (msg_pkts[i]) begin
            tick($urandom_range(0, 3));
            fifo_q.push_back(msg_pkts[i]);
        end
        tick(2);
        msg_end = 1'b1;
        wait_done(600, 1'b0);
    endtask

    task automatic rand_msg(input int n);
        msg_pkts.delete();
        for (int i = 0; i < n; i++) msg_pkts.push_back(PW'($urandom_range(0, 255)));
    endtask

    // scoreboard monitor
    blk_s held;
    bit   hold_v;
    bit   rd_prev;
    always @(negedge clk) begin
        blk_s e;
        if (!reset_n) begin
            hold_v  = 1'b0;
            rd_prev = 1'b0;
        end else begin
            if (fifo_rd) check("fifo_rd_back_to_back", 64'(rd_prev), 64'd0);
            rd_prev = fifo_rd;
            if (blk_valid) check("fifo_rd_in_send", 64'(fifo_rd), 64'd0);
            if (blk_valid && hold_v) begin
                check("stall_data", 64'(blk_data), 64'(held.data));
                check("stall_t",    64'(blk_t),    64'(held.t));
                check("stall_last", 64'(blk_last), 64'(held.last));
            end
            if (blk_valid && blk_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_block", 64'(blk_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("blk_data", 64'(blk_data), 64'(e.data));
                    check("blk_t",    64'(blk_t),    64'(e.t));
                    check("blk_last", 64'(blk_last), 64'(e.last));
                end
                hold_v = 1'b0;
            end else if (blk_valid) begin
                hold_v    = 1'b1;
                held.data = blk_data;
                held.t    = blk_t;
                held.last = blk_last;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    initial begin
        int c;
        reset_n   = 1'b0;
        start     = 1'bx;
        msg_end   = 1'bx;
        blk_ready = 1'bx;
        tick(3);
        start     = 1'b0;
        msg_end   = 1'b0;
        blk_ready = 1'b1;
        tick(1);
        reset_n = 1'b1;
        tick(1);
        check("rst_blk_valid", 64'(blk_valid), 64'd0);
        check("rst_fifo_rd",   64'(fifo_rd),   64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_blk_t",     64'(blk_t),     64'd0);
        check("rst_blk_last",  64'(blk_last),  64'd0);
        check("rst_blk_data",  64'(blk_data),  64'd0);

        // 8 packets: two full blocks, the second final
        msg_pkts.delete();
        for (int i = 1; i <= 8; i++) msg_pkts.push_back(PW'(i));
        run_preloaded(1'b0);

        // 6 packets: partial final block zero-padded
        msg_pkts.delete();
        for (int i = 0; i < 6; i++) msg_pkts.push_back(PW'(8'hA1 + i));
        run_preloaded(1'b0);

        // empty message
        msg_pkts.delete();
        run_preloaded(1'b0);

        // full block waits in HOLD while the FIFO is empty and msg_end is low
        rand_msg(5);
        expect_msg();
        for (int i = 0; i < 4; i++) fifo_q.push_back(msg_pkts[i]);
        msg_end = 1'b0;
        tick(1);
        pulse_start();
        tick(12);
        for (int i = 0; i < 10; i++) begin
            check("hold_no_valid", 64'(blk_valid), 64'd0);
            check("hold_busy",     64'(busy),      64'd1);
            tick(1);
        end
        fifo_q.push_back(msg_pkts[4]);
        tick(8);
        msg_end = 1'b1;
        wait_done(200, 1'b0);

        // stalled core: block held stable for 5 cycles
        rand_msg(3);
        blk_ready = 1'b0;
        expect_msg();
        foreach (msg_pkts[i]) fifo_q.push_back(msg_pkts[i]);
        msg_end = 1'b1;
        tick(1);
        pulse_start();
        c = 0;
        while (!blk_valid && c < 100) begin
            tick(1);
            c++;
        end
        check("stall_valid_seen", 64'(blk_valid), 64'd1);
        tick(5);
        check("stall_still_valid", 64'(blk_valid), 64'd1);
        blk_ready = 1'b1;
        wait_done(100, 1'b0);

        // randomized messages with random ready back-pressure
        for (int k = 0; k < 6; k++) begin
            rand_msg($urandom_range(0, 11));
            run_preloaded(1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            rand_msg($urandom_range(1, 10));
            run_gradual();
        end

        // reset in the middle of filling a block
        rand_msg(3);
        foreach (msg_pkts[i]) fifo_q.push_back(msg_pkts[i]);
        msg_end = 1'b0;
        tick(1);
        pulse_start();
        tick(3);
        reset_n = 1'b0;
        #1;
        check("midrst_blk_valid", 64'(blk_valid), 64'd0);
        check("midrst_fifo_rd",   64'(fifo_rd),   64'd0);
        check("midrst_busy",      64'(busy),      64'd0);
        check("midrst_blk_t",     64'(blk_t),     64'd0);
        check("midrst_blk_data",  64'(blk_data),  64'd0);
        check("midrst_blk_last",  64'(blk_last),  64'd0);
        fifo_q.delete();
        tick(2);
        reset_n = 1'b1;
        tick(2);
        check("post_rst_busy", 64'(busy), 64'd0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
